// File: rtl/restoring_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package restoring_divider_pkg;

  // Controller states: waiting for work, iterating, presenting a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width of the step counter. It must hold WIDTH-1, and it is at least one bit wide.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/borrow_sub_n.sv
// N-bit ripple borrow subtractor built from a chain of full_subtractor cells.
module borrow_sub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] D,
  output logic         Bout
);

  // borrow[i] is the borrow into bit i. The last entry is the overall borrow out.
  logic [N:0] borrow;

  assign borrow[0] = Bin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      full_subtractor u_fs (
        .a    (A[gi]),
        .b    (B[gi]),
        .bin  (borrow[gi]),
        .d    (D[gi]),
        .bout (borrow[gi+1])
      );
    end
  endgenerate

  assign Bout = borrow[N];

endmodule

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with a borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider. It performs one trial subtraction per
// cycle. The borrow out of the trial decides whether the difference is kept or
// the partial remainder is restored. The handshake is start/done, and only one
// operation is in flight at a time.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic             ready_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dz_reg;

  // Trial subtraction datapath. The partial remainder is shifted left and
  // takes in the next dividend bit.
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   diff;
  logic             bout;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign s = {r_reg, q_reg[WIDTH-1]};

  borrow_sub_n #(
    .N (WIDTH + 1)
  ) u_sub (
    .A    (s),
    .B    ({1'b0, divisor_reg}),
    .Bin  (1'b0),
    .D    (diff),
    .Bout (bout)
  );

  // A borrow means the divisor did not fit. In that case the shifted
  // remainder is restored and a 0 quotient bit is recorded.
  assign r_next = bout ? s[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_next = {q_reg[WIDTH-2:0], ~bout};

  // When there is no borrow, the top difference bit is always zero, so it is never needed.
  logic unused_diff_msb;
  assign unused_diff_msb = diff[WIDTH];

  assign ready       = ready_reg;
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dz_reg;

  // Controller, iteration registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      q_reg         <= '0;
      count_reg     <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      ready_reg     <= 1'b1;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dz_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            r_reg        <= '0;
            q_reg        <= dividend;
            count_reg    <= CW'(WIDTH - 1);
            ready_reg    <= 1'b0;
            state_reg    <= (divisor == '0) ? DONE : CALC;
          end
        end

        CALC: begin
          r_reg     <= r_next;
          q_reg     <= q_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == '0) begin
            // The final step's result is published directly, so done
            // coincides with the DONE state.
            state_reg     <= DONE;
            done_reg      <= 1'b1;
            quotient_reg  <= q_next;
            remainder_reg <= r_next;
            dz_reg        <= 1'b0;
          end
        end

        DONE: begin
          if (done_reg) begin
            done_reg  <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else begin
            // A divide-by-zero enters DONE straight from IDLE. It publishes
            // its saturated result one cycle later, then leaves through the
            // branch above.
            done_reg      <= 1'b1;
            quotient_reg  <= '1;
            remainder_reg <= dividend_reg;
            dz_reg        <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider. It uses a 4-bit and an 8-bit instance.
// The expected results come from plain integer division.
module tb_restoring_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start4, ready4, done4, dz4;
  logic [3:0] dvd4, dvs4, q4, r4;
  logic       start8, ready8, done8, dz8;
  logic [7:0] dvd8, dvs8, q8, r8;

  restoring_divider #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
    .ready(ready4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dz4)
  );

  restoring_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .ready(ready8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned a, b, q, r;
    bit          dz;
    int          due;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division. A zero divisor saturates the quotient and
  // returns the dividend.
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input int w, input int acc);
    exp_t e;
    int unsigned mask;
    mask  = (32'd1 << w) - 32'd1;
    e.a   = a;
    e.b   = b;
    if (b == 0) begin
      e.q   = mask;
      e.r   = a;
      e.dz  = 1'b1;
      e.due = acc + 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dz  = 1'b0;
      e.due = acc + w;
    end
    return e;
  endfunction

  task automatic check_result(input string tag, input exp_t e, input int unsigned q,
                              input int unsigned r, input bit dz);
    $display("%s %0d/%0d -> q=%0d r=%0d dz=%0d (want q=%0d r=%0d dz=%0d) cycle %0d",
             tag, e.a, e.b, q, r, dz, e.q, e.r, e.dz, cyc);
    check({tag, " quotient"}, q, e.q);
    check({tag, " remainder"}, r, e.r);
    check({tag, " div_by_zero"}, dz, e.dz);
    check({tag, " latency"}, cyc, e.due);
    if (!e.dz) begin
      check({tag, " invariant q*d+r"}, q * e.b + r, e.a);
      check({tag, " invariant r<d"}, (r < e.b) ? 1 : 0, 1);
    end
  endtask

  // Monitors: pop one expectation per done pulse, then confirm ready on the next cycle.
  bit rchk4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) rchk4 = 1'b0;
    else begin
      if (rchk4) begin
        check("w4 ready after done", ready4, 1);
        rchk4 = 1'b0;
      end
      if (done4) begin
        if (sb4.size() == 0) check("w4 unexpected done", done4, 0);
        else begin
          e = sb4.pop_front();
          check_result("w4", e, q4, r4, dz4);
          rchk4 = 1'b1;
        end
      end
    end
  end

  bit rchk8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) rchk8 = 1'b0;
    else begin
      if (rchk8) begin
        check("w8 ready after done", ready8, 1);
        rchk8 = 1'b0;
      end
      if (done8) begin
        if (sb8.size() == 0) check("w8 unexpected done", done8, 0);
        else begin
          e = sb8.pop_front();
          check_result("w8", e, q8, r8, dz8);
          rchk8 = 1'b1;
        end
      end
    end
  end

  // Drivers: called at a falling edge. Each waits (bounded) for ready, then
  // presents one start pulse and scrambles the operands afterwards.
  task automatic issue4(input int unsigned a, input int unsigned b);
    int n = 0;
    while (!ready4 && n < 50) begin @(negedge clk); n++; end
    if (!ready4) begin check("w4 ready timeout", ready4, 1); return; end
    start4 = 1'b1;
    dvd4   = a[3:0];
    dvs4   = b[3:0];
    sb4.push_back(model(a, b, 4, cyc + 1));
    @(negedge clk);
    start4 = 1'b0;
    dvd4   = 4'($urandom);
    dvs4   = 4'($urandom);
  endtask

  task automatic issue8(input int unsigned a, input int unsigned b);
    int n = 0;
    while (!ready8 && n < 50) begin @(negedge clk); n++; end
    if (!ready8) begin check("w8 ready timeout", ready8, 1); return; end
    start8 = 1'b1;
    dvd8   = a[7:0];
    dvs8   = b[7:0];
    sb8.push_back(model(a, b, 8, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    dvd8   = 8'($urandom);
    dvs8   = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb4.size() != 0 || sb8.size() != 0) && n < 300) begin @(negedge clk); n++; end
    check("scoreboard drained", sb4.size() + sb8.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start4 = 1'b0; dvd4 = '0; dvs4 = '0;
    start8 = 1'b0; dvd8 = '0; dvs8 = '0;
    repeat (2) @(negedge clk);
    check("reset ready4", ready4, 1);
    check("reset done4", done4, 0);
    check("reset quotient4", q4, 0);
    check("reset remainder4", r4, 0);
    check("reset dz4", dz4, 0);
    check("reset ready8", ready8, 1);
    rst = 1'b0;
    @(negedge clk);

    // Basic case, dividend < divisor followed back-to-back by divisor=1, and divide by zero.
    issue4(13, 3);
    drain();
    issue4(7, 9);
    issue4(15, 1);
    drain();
    issue4(9, 0);
    drain();

    // A start during CALC must be ignored. The monitor flags any extra done.
    issue4(13, 3);
    start4 = 1'b1; dvd4 = 4'd6; dvs4 = 4'd2;
    repeat (2) @(negedge clk);
    start4 = 1'b0;
    drain();

    // Reset mid-operation aborts with no done pulse and clears the outputs.
    issue4(13, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb4.delete();
    check("abort ready4", ready4, 1);
    check("abort done4", done4, 0);
    check("abort quotient4", q4, 0);
    check("abort remainder4", r4, 0);
    check("abort dz4", dz4, 0);
    repeat (6) @(negedge clk);
    issue4(14, 4);
    drain();

    // 8-bit directed and random cases, with 4-bit random traffic running alongside.
    issue8(255, 16);
    issue8(200, 7);
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          int unsigned a, b;
          a = $urandom_range(0, 255);
          b = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
          issue8(a, b);
        end
      end
      begin
        for (int j = 0; j < 80; j++) begin
          issue4($urandom_range(0, 15), $urandom_range(0, 15));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
